// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: boot-time loader that assembles a framed byte stream into instruction words,
// writes them to instruction memory and releases the core once the frame checksum matches.
module imem_loader #(
  parameter int         DATA_W     = 24,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] START_BYTE = 8'hA5
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic [7:0]        iw_byte,
  input  logic              iw_byte_valid,
  output logic              ow_byte_ready,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  output logic              or_core_rst,
  output logic              ow_busy,
  output logic              ow_err,
  output logic [ADDR_W:0]   ow_words_loaded
);

  localparam int BYTES = DATA_W / 8;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [BI_W-1:0]   byte_idx;
  logic [DATA_W-1:0] word_sr;
  logic [7:0]        csum;
  logic [ADDR_W:0]   words;
  logic              core_rst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              accept;
  logic              start_frame;
  logic              data_byte;
  logic              word_done;
  logic              last_word;
  logic              len_over;
  logic [15:0]       len_next;
  logic [DATA_W-1:0] word_next;

  assign accept    = iw_byte_valid & ~iw_rst;
  assign len_next  = {len_hi, iw_byte};
  assign len_over  = 64'(len_next) > (64'd1 << ADDR_W);
  assign word_done = (byte_idx == BI_W'(BYTES - 1));
  assign last_word = (32'(words) + 32'd1) == 32'(len);
  assign word_next = (word_sr << 8) | DATA_W'(iw_byte);

  always_ff @(posedge iw_clk) begin
    if (iw_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (iw_byte == START_BYTE) state_next = S_LEN_HI;
        S_LEN_HI:              state_next = S_LEN_LO;
        S_LEN_LO: begin
          if (len_over)              state_next = S_ERR;
          else if (len_next == '0)   state_next = S_CSUM;
          else                       state_next = S_DATA;
        end
        S_DATA:                if (word_done && last_word) state_next = S_CSUM;
        S_CSUM:                state_next = (iw_byte == csum) ? S_DONE : S_ERR;
        default:               state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ow_byte_ready = ~iw_rst;
    ow_busy       = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
    ow_err        = (state == S_ERR);
    start_frame   = accept && (iw_byte == START_BYTE) &&
                    ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    data_byte     = accept && (state == S_DATA);
  end

  // Write pipeline registers are separate from word_sr so the next word can start shifting immediately.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      len_hi    <= '0;
      len       <= '0;
      byte_idx  <= '0;
      word_sr   <= '0;
      csum      <= '0;
      words     <= '0;
      core_rst  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we   <= 1'b0;
      core_rst <= (state_next != S_DONE);
      if (start_frame) begin
        words    <= '0;
        csum     <= '0;
        byte_idx <= '0;
      end
      if (accept && (state == S_LEN_HI)) len_hi <= iw_byte;
      if (accept && (state == S_LEN_LO)) len    <= len_next;
      if (data_byte) begin
        word_sr  <= word_next;
        csum     <= csum ^ iw_byte;
        byte_idx <= word_done ? '0 : byte_idx + 1'b1;
        if (word_done) begin
          mem_we    <= 1'b1;
          mem_addr  <= words[ADDR_W-1:0];
          mem_wdata <= word_next;
          words     <= words + 1'b1;
        end
      end
    end
  end

  assign ow_mem_we       = mem_we;
  assign ow_mem_addr     = mem_addr;
  assign ow_mem_wdata    = mem_wdata;
  assign or_core_rst     = core_rst;
  assign ow_words_loaded = words;

endmodule
`default_nettype wire
